// File: rtl/pwm_meas_scheduler.sv
// pwm_meas_scheduler: one pulse-width measurement engine shared round-robin
// across N_CH PWM inputs. For each picked channel it settles, measures one
// full high/low period through a synchronizer, flags stuck lines by timeout,
// and holds the result on a valid/ack interface until it is consumed.
module pwm_meas_scheduler #(
  parameter int N_CH           = 3,
  parameter int CH_W           = 3,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              pwd_clk,
  input  logic              sysreset,
  input  logic [N_CH-1:0]   pwm_in,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              result_ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [31:0]       result_high,
  output logic [31:0]       result_low,
  output logic [1:0]        result_status
);

  localparam logic [31:0] SETTLE_N  = 32'(SETTLE_CYCLES);
  localparam logic [31:0] TIMEOUT_N = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_LOW   = 2'b01;
  localparam logic [1:0] ST_HIGH  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SETTLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, REPORT
  } state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic [31:0]       hi_lat;
  logic [CH_W-1:0]   rr_ptr;     // search start for the next pick (inclusive)

  logic              pwm_sel;
  logic              s1, sync, prev;
  logic              rise, fall;

  logic [N_CH-1:0]   rot;
  int                off;
  int                pick_i;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   ptr_nxt;
  logic              can_start;

  // Mux the selected raw line; compare-based so ch_sel width never has to
  // match the pwm_in index range.
  always_comb begin
    pwm_sel = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (ch_sel == CH_W'(i)) pwm_sel = pwm_in[i];
  end

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      s1   <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= pwm_sel;
      sync <= s1;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

  // Next channel: rotate the mask so rr_ptr lands on bit 0, take the lowest
  // set bit, then rotate the offset back. rr_ptr is one past the last pick,
  // so a lone masked-in channel wraps around onto itself.
  always_comb begin
    rot    = N_CH'({ch_mask, ch_mask} >> rr_ptr);
    off    = 0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rot[i]) off = i;
    pick_i = int'(rr_ptr) + off;
    if (pick_i >= N_CH) pick_i = pick_i - N_CH;
    pick_ch = CH_W'(pick_i);
    ptr_nxt = (pick_i == N_CH - 1) ? '0 : CH_W'(pick_i + 1);
  end

  assign can_start = enable & (|ch_mask);

  // Scheduler / measurement FSM; all outputs are registered here.
  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      state         <= IDLE;
      cnt           <= '0;
      hi_lat        <= '0;
      rr_ptr        <= '0;
      ch_sel        <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_ch     <= '0;
      result_high   <= '0;
      result_low    <= '0;
      result_status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_start) begin
            ch_sel <= pick_ch;
            rr_ptr <= ptr_nxt;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end

        // Let the synchronizer flush the previous channel before arming edges.
        SETTLE: begin
          if (cnt + 32'd1 >= SETTLE_N) begin
            cnt   <= '0;
            state <= WAIT_RISE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        // Measurement starts on a rising edge so a full period is captured.
        WAIT_RISE: begin
          if (rise) begin
            cnt   <= 32'd1;
            state <= MEAS_HIGH;
          end else if (cnt == TIMEOUT_N) begin
            result_valid  <= 1'b1;
            result_ch     <= ch_sel;
            result_status <= sync ? ST_HIGH : ST_LOW;
            result_high   <= sync ? TIMEOUT_N : 32'd0;
            result_low    <= sync ? 32'd0 : TIMEOUT_N;
            cnt           <= '0;
            state         <= REPORT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        MEAS_HIGH: begin
          if (fall) begin
            hi_lat <= cnt;
            cnt    <= 32'd1;
            state  <= MEAS_LOW;
          end else if (cnt == TIMEOUT_N) begin
            result_valid  <= 1'b1;
            result_ch     <= ch_sel;
            result_status <= ST_HIGH;
            result_high   <= TIMEOUT_N;
            result_low    <= 32'd0;
            cnt           <= '0;
            state         <= REPORT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        MEAS_LOW: begin
          if (rise) begin
            result_valid  <= 1'b1;
            result_ch     <= ch_sel;
            result_status <= ST_OK;
            result_high   <= hi_lat;
            result_low    <= cnt;
            cnt           <= '0;
            state         <= REPORT;
          end else if (cnt == TIMEOUT_N) begin
            result_valid  <= 1'b1;
            result_ch     <= ch_sel;
            result_status <= ST_LOW;
            result_high   <= hi_lat;
            result_low    <= TIMEOUT_N;
            cnt           <= '0;
            state         <= REPORT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        // Hold the result until acked; the pick for the next channel uses the
        // enable/mask seen on the ack edge.
        REPORT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            if (can_start) begin
              ch_sel <= pick_ch;
              rr_ptr <= ptr_nxt;
              cnt    <= '0;
              state  <= SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_meas_scheduler.sv
// tb_pwm_meas_scheduler: drives clock-synchronous PWM waveforms (or stuck
// levels) per channel and checks every presented result against a model that
// knows each channel's configured high/low lengths and the round-robin rule.
module tb_pwm_meas_scheduler;

  localparam int NCH = 3;
  localparam int CHW = 3;
  localparam int SET = 16;
  localparam int TMO = 100;

  logic            pwd_clk = 1'b0;
  logic            sysreset = 1'b0;
  logic [NCH-1:0]  pwm_in = '0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  ch_mask = '0;
  logic            result_ack = 1'b0;
  logic [CHW-1:0]  ch_sel;
  logic            busy;
  logic            result_valid;
  logic [CHW-1:0]  result_ch;
  logic [31:0]     result_high;
  logic [31:0]     result_low;
  logic [1:0]      result_status;

  int total = 0;
  int bad   = 0;

  // Per-channel waveform config: either PWM (hi/lo clocks) or a constant level.
  int cfg_hi[NCH]    = '{10, 10, 10};
  int cfg_lo[NCH]    = '{10, 10, 10};
  bit cfg_const[NCH] = '{0, 0, 0};
  bit cfg_lvl[NCH]   = '{0, 0, 0};
  int ph[NCH]        = '{0, 0, 0};

  // Model state
  int m_last = -1;
  int exp_ch, exp_hi, exp_lo, exp_st;

  pwm_meas_scheduler #(
    .N_CH(NCH), .CH_W(CHW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pwd_clk(pwd_clk), .sysreset(sysreset), .pwm_in(pwm_in), .enable(enable),
    .ch_mask(ch_mask), .result_ack(result_ack), .ch_sel(ch_sel), .busy(busy),
    .result_valid(result_valid), .result_ch(result_ch),
    .result_high(result_high), .result_low(result_low),
    .result_status(result_status)
  );

  always #5 pwd_clk = ~pwd_clk;

  // Waveform generator: updates just after each rising edge.
  initial begin
    forever begin
      @(posedge pwd_clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (cfg_const[c]) pwm_in[c] = cfg_lvl[c];
        else begin
          pwm_in[c] = (ph[c] < cfg_hi[c]);
          ph[c] = (ph[c] + 1) % (cfg_hi[c] + cfg_lo[c]);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Next expected result: first masked-in channel after the last one, cyclic;
  // its values follow from how that channel's line is being driven.
  task automatic model_next();
    int c;
    bit found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_last + k) % NCH;
      if (!found && ch_mask[c]) begin
        exp_ch = c;
        found  = 1'b1;
      end
    end
    if (cfg_const[exp_ch]) begin
      exp_st = cfg_lvl[exp_ch] ? 2 : 1;
      exp_hi = cfg_lvl[exp_ch] ? TMO : 0;
      exp_lo = cfg_lvl[exp_ch] ? 0 : TMO;
    end else begin
      exp_st = 0;
      exp_hi = cfg_hi[exp_ch];
      exp_lo = cfg_lo[exp_ch];
    end
    m_last = exp_ch;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",   busy, 0);
    chk("rst_valid",  result_valid, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_res_ch", result_ch, 0);
    chk("rst_high",   result_high, 0);
    chk("rst_low",    result_low, 0);
    chk("rst_status", result_status, 0);
  endtask

  // Wait (bounded) for a result, compare it, then keep ack low for d cycles
  // while checking it stays put.
  task automatic take_result(input int d);
    int n = 0;
    while (result_valid !== 1'b1 && n < 2000) begin
      @(negedge pwd_clk);
      n++;
    end
    if (result_valid !== 1'b1) begin
      chk("result_wait", 0, 1);
      return;
    end
    model_next();
    chk("res_ch", result_ch, exp_ch);
    chk("ch_sel", ch_sel, exp_ch);
    chk("res_high", result_high, exp_hi);
    chk("res_low", result_low, exp_lo);
    chk("res_status", result_status, exp_st);
    chk("busy_rep", busy, 1);
    repeat (d) begin
      @(negedge pwd_clk);
      chk("hold_valid", result_valid, 1);
      chk("hold_high", result_high, exp_hi);
      chk("hold_low", result_low, exp_lo);
      chk("hold_ch_sel", ch_sel, exp_ch);
    end
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    @(posedge pwd_clk);
    #1;
    result_ack = 1'b0;
    chk("ack_valid", result_valid, 0);
    chk("kept_high", result_high, exp_hi);
    chk("kept_low", result_low, exp_lo);
    chk("kept_status", result_status, exp_st);
    chk("kept_ch", result_ch, exp_ch);
    @(negedge pwd_clk);
  endtask

  task automatic pulse_ack();
    result_ack = 1'b1;
    @(posedge pwd_clk);
    #1;
    result_ack = 1'b0;
    @(negedge pwd_clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
  endtask

  initial begin
    int n, rise_n, fall_n;
    bit pv;

    // Reset state
    repeat (3) @(negedge pwd_clk);
    chk_reset_outputs();
    sysreset = 1'b1;
    repeat (10) @(negedge pwd_clk);
    chk_idle("idle_dis");
    enable = 1'b1;
    repeat (10) @(negedge pwd_clk);
    chk_idle("idle_nomask");

    // Single channel 30/70, quick acks, re-picked every time
    cfg_hi[0] = 30; cfg_lo[0] = 70;
    ch_mask = 3'b001;
    for (int r = 0; r < 3; r++) begin
      take_result(1);
      if (r == 2) enable = 1'b0;
      do_ack();
    end
    repeat (3) @(negedge pwd_clk);
    chk_idle("t1_end");

    // Two channels alternate, ch1 skipped
    cfg_hi[0] = 10; cfg_lo[0] = 10;
    cfg_hi[1] = 5;  cfg_lo[1] = 5;
    cfg_hi[2] = 40; cfg_lo[2] = 20;
    ch_mask = 3'b101;
    enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      take_result(1);
      if (r == 3) enable = 1'b0;
      do_ack();
    end
    repeat (3) @(negedge pwd_clk);
    chk_idle("t2_end");

    // Stuck low, then stuck high with a long ack hold; stray ack while invalid
    cfg_const[1] = 1'b1; cfg_lvl[1] = 1'b0;
    ch_mask = 3'b010;
    enable = 1'b1;
    take_result(2);
    cfg_lvl[1] = 1'b1;
    do_ack();
    repeat (5) @(negedge pwd_clk);
    pulse_ack();
    take_result(50);
    enable = 1'b0;
    do_ack();
    pulse_ack();
    repeat (10) @(negedge pwd_clk);
    chk_idle("t3_end");
    cfg_const[1] = 1'b0;

    // Mask cleared while reporting: return to IDLE after ack
    cfg_hi[0] = 20; cfg_lo[0] = 20;
    ch_mask = 3'b001;
    enable = 1'b1;
    take_result(0);
    ch_mask = 3'b000;
    do_ack();
    repeat (10) @(negedge pwd_clk);
    chk_idle("t4_end");

    // enable dropped while the high phase is being measured
    cfg_hi[0] = 40; cfg_lo[0] = 20;
    ch_mask = 3'b001;
    enable = 1'b1;
    n = 0; rise_n = -1; pv = pwm_in[0];
    while (!(rise_n >= 15 && n == rise_n + 5) && n < 300) begin
      @(negedge pwd_clk);
      n++;
      if (pwm_in[0] && !pv && rise_n < 15) rise_n = n;
      pv = pwm_in[0];
    end
    enable = 1'b0;
    take_result(1);
    do_ack();
    repeat (2) @(negedge pwd_clk);
    chk_idle("t5_after");
    repeat (40) @(negedge pwd_clk);
    chk_idle("t5_stay");

    // Async reset while ch1 is in its low phase; restart from ch0
    cfg_hi[0] = 20; cfg_lo[0] = 20;
    cfg_hi[1] = 30; cfg_lo[1] = 30;
    ch_mask = 3'b011;
    enable = 1'b1;
    n = 0; rise_n = -1; fall_n = -1; pv = pwm_in[1];
    while (!(fall_n > 0 && n == fall_n + 5) && n < 400) begin
      @(negedge pwd_clk);
      n++;
      if (pwm_in[1] && !pv && rise_n < 15) rise_n = n;
      if (!pwm_in[1] && pv && rise_n >= 15 && fall_n < 0) fall_n = n;
      pv = pwm_in[1];
    end
    chk("pre_rst_busy", busy, 1);
    #2 sysreset = 1'b0;
    #1 chk_reset_outputs();
    m_last = -1;
    repeat (2) @(negedge pwd_clk);
    sysreset = 1'b1;
    take_result(1);
    do_ack();
    take_result(1);
    enable = 1'b0;
    do_ack();
    repeat (3) @(negedge pwd_clk);
    chk_idle("t6_end");

    // Randomized blocks: random waveforms, masks, ack delays
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < NCH; c++) begin
        cfg_const[c] = ($urandom_range(0, 5) == 0);
        cfg_lvl[c]   = 1'($urandom_range(0, 1));
        cfg_hi[c]    = $urandom_range(2, 40);
        cfg_lo[c]    = $urandom_range(2, 40);
      end
      ch_mask = NCH'($urandom_range(1, 7));
      enable = 1'b1;
      for (int r = 0; r < 6; r++) begin
        take_result($urandom_range(0, 8));
        if (r == 5) enable = 1'b0;
        else if ($urandom_range(0, 2) == 0) ch_mask = NCH'($urandom_range(1, 7));
        do_ack();
      end
      repeat (3) @(negedge pwd_clk);
      chk_idle("rnd_end");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
